// File: rtl/ap_ctrl_event_recorder.sv
// ap_ctrl_event_recorder: watches NUM_MOD ap_ctrl_hs handshakes and turns each
// start/done transition into a timestamped record {type, id, ts}. Records go
// through a per-module slot, a lowest-index-first arbiter and a FIFO. The FIFO
// feeds a valid/ready consumer. A single FINISH record closes the run.
// Optional feature macro: EVREC_TS_SAT_EN (timestamp saturates instead of wrapping).
module ap_ctrl_event_recorder #(
    parameter int NUM_MOD    = 5,
    parameter int ID_W       = 3,
    parameter int TS_W       = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     finish,
    input  logic [NUM_MOD-1:0]       mod_start,
    input  logic [NUM_MOD-1:0]       mod_done,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [2+ID_W+TS_W-1:0]   ev_data,
    output logic [15:0]              overflow_cnt,
    output logic                     busy
);
    localparam int REC_W = 2 + ID_W + TS_W;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {IDLE, RUN} mod_state_t;
    typedef enum logic [1:0] {RUNNING, FLUSH, STOPPED} fin_state_t;

    logic [TS_W-1:0]  ts_cnt;
    mod_state_t       mst       [NUM_MOD];
    logic [NUM_MOD-1:0] slot_full;
    logic [1:0]       slot_type [NUM_MOD];
    logic [TS_W-1:0]  slot_ts   [NUM_MOD];
    fin_state_t       fstate;

    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;

    logic             fifo_full, capture, fin_push, push, pop;
    logic [NUM_MOD-1:0] ev_new, grant;
    logic [1:0]       ev_typ [NUM_MOD];
    logic [REC_W-1:0] arb_rec, push_data;
    logic [3:0]       drop_n;
    logic [16:0]      ovf_sum;

    assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
    assign capture   = (fstate == RUNNING);
    assign ev_valid  = (count != '0);
    assign ev_data   = ev_valid ? mem[rptr] : '0;
    assign pop       = ev_valid && ev_ready;
    assign fin_push  = (fstate == FLUSH) && (slot_full == '0) && !fifo_full;
    assign push      = (grant != '0) || fin_push;
    assign push_data = fin_push ? {2'b11, {ID_W{1'b0}}, ts_cnt} : arb_rec;
    assign ovf_sum   = {1'b0, overflow_cnt} + 17'(drop_n);

    // Event detection per module: START from IDLE wins over a simultaneous done.
    always_comb begin
        for (int i = 0; i < NUM_MOD; i++) begin
            ev_typ[i] = (mst[i] == RUN) ? 2'b01 : 2'b00;
            ev_new[i] = capture && (((mst[i] == IDLE) && mod_start[i]) ||
                                    ((mst[i] == RUN)  && mod_done[i]));
        end
    end

    // Fixed-priority arbiter: lowest-index full slot moves when the FIFO has room.
    always_comb begin
        grant   = '0;
        arb_rec = '0;
        for (int i = NUM_MOD-1; i >= 0; i--) begin
            if (slot_full[i] && !fifo_full) begin
                grant   = '0;
                grant[i] = 1'b1;
                arb_rec = {slot_type[i], ID_W'(i), slot_ts[i]};
            end
        end
    end

    // Count events lost because their slot stays occupied this cycle.
    always_comb begin
        drop_n = '0;
        for (int i = 0; i < NUM_MOD; i++)
            if (ev_new[i] && slot_full[i] && !grant[i])
                drop_n = drop_n + 4'd1;
    end

    // Free-running timestamp; wraps, or sticks at all-ones when saturation is built in.
    always_ff @(posedge clock) begin
        if (reset)
            ts_cnt <= '0;
`ifdef EVREC_TS_SAT_EN
        else if (ts_cnt != {TS_W{1'b1}})
            ts_cnt <= ts_cnt + TS_W'(1);
`else
        else
            ts_cnt <= ts_cnt + TS_W'(1);
`endif
    end

    // Per-module handshake FSM and its single-entry event slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_MOD; i++) begin
                mst[i]       <= IDLE;
                slot_full[i] <= 1'b0;
                slot_type[i] <= '0;
                slot_ts[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MOD; i++) begin
                if (ev_new[i])
                    mst[i] <= (mst[i] == IDLE) ? RUN : IDLE;
                if (ev_new[i] && (!slot_full[i] || grant[i])) begin
                    slot_full[i] <= 1'b1;
                    slot_type[i] <= ev_typ[i];
                    slot_ts[i]   <= ts_cnt;
                end else if (grant[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

    // FIFO pointers and occupancy; push only uses the start-of-cycle full flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (!push && pop) count <= count - (AW+1)'(1);
        end
    end

    // FIFO storage; contents past the pointers are don't-care, so no reset.
    always_ff @(posedge clock) begin
        if (push)
            mem[wptr] <= push_data;
    end

    // Saturating dropped-event counter.
    always_ff @(posedge clock) begin
        if (reset)
            overflow_cnt <= '0;
        else
            overflow_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end

    // End-of-run FSM: freeze capture, flush slots, enqueue FINISH, then stop.
    always_ff @(posedge clock) begin
        if (reset) begin
            fstate <= RUNNING;
            busy   <= 1'b0;
        end else begin
            case (fstate)
                RUNNING: if (finish) fstate <= FLUSH;
                FLUSH:   if (fin_push) fstate <= STOPPED;
                default: fstate <= STOPPED;
            endcase
            busy <= !((fstate == STOPPED) || fin_push);
        end
    end

endmodule
